// File: rtl/game_flow_ctrl.sv
// Round flow controller: debounces the board button, sequences menu/play/end screens,
// gates the game logic, pulses the round reset and keeps saturating win tallies.
module game_flow_ctrl #(
    parameter int DEBOUNCE_CYCLES = 650_000,
    parameter int END_HOLD_CYCLES = 65_000_000,
    parameter int GUARD_CYCLES    = 2,
    parameter int WIN_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_button,
    input  logic [1:0]       gameover,
    output logic             game_en,
    output logic             game_rst,
    output logic [1:0]       screen_sel,
    output logic [WIN_W-1:0] tom_wins,
    output logic [WIN_W-1:0] jerry_wins
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W  = (END_HOLD_CYCLES > 0) ? $clog2(END_HOLD_CYCLES + 1) : 1;
    localparam int GUARD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        RESTART   = 3'd1,
        PLAYING   = 3'd2,
        TOM_WON   = 3'd3,
        JERRY_WON = 3'd4
    } state_t;

    logic               syncMeta_q, syncOut_q;
    logic [DB_W-1:0]    dbCnt_q, dbCnt_d;
    logic               dbLevel_q, dbLevel_d;
    logic               press_q, press_d;

    state_t             state_q;
    logic [GUARD_W-1:0] guard_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               gameEn_q, gameRst_q;
    logic [1:0]         screen_q;
    logic [WIN_W-1:0]   tomWins_q, jerryWins_q;

    logic               enterRestart, enterTom, enterJerry;

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        dbCnt_d   = '0;
        dbLevel_d = dbLevel_q;
        press_d   = 1'b0;
        if (syncOut_q != dbLevel_q) begin
            if (dbCnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                dbLevel_d = ~dbLevel_q;
                press_d   = ~dbLevel_q;
            end else begin
                dbCnt_d = dbCnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
            dbCnt_q    <= '0;
            dbLevel_q  <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            syncMeta_q <= rst_button;
            syncOut_q  <= syncMeta_q;
            dbCnt_q    <= dbCnt_d;
            dbLevel_q  <= dbLevel_d;
            press_q    <= press_d;
        end
    end

    // A valid gameover outranks a simultaneous press; Tom outranks Jerry.
    always_comb begin
        enterRestart = 1'b0;
        enterTom     = 1'b0;
        enterJerry   = 1'b0;
        case (state_q)
            MENU: enterRestart = press_q;
            PLAYING: begin
                if (guard_q == '0 && gameover[1]) begin
                    enterTom = 1'b1;
                end else if (guard_q == '0 && gameover[0]) begin
                    enterJerry = 1'b1;
                end else begin
                    enterRestart = press_q;
                end
            end
            TOM_WON, JERRY_WON: enterRestart = press_q && (hold_q == '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MENU;
            guard_q      <= '0;
            hold_q       <= '0;
            gameEn_q     <= 1'b0;
            gameRst_q    <= 1'b0;
            screen_q     <= 2'b00;
            tomWins_q    <= '0;
            jerryWins_q  <= '0;
        end else begin
            gameRst_q <= 1'b0;
            if (state_q == PLAYING && guard_q != '0) begin
                guard_q <= guard_q - GUARD_W'(1);
            end
            if ((state_q == TOM_WON || state_q == JERRY_WON) && hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
            end

            if (enterRestart) begin
                state_q   <= RESTART;
                gameRst_q <= 1'b1;
                gameEn_q  <= 1'b0;
                screen_q  <= 2'b01;
                guard_q   <= GUARD_W'(GUARD_CYCLES);
            end else if (enterTom) begin
                state_q   <= TOM_WON;
                gameEn_q  <= 1'b0;
                screen_q  <= 2'b10;
                hold_q    <= HOLD_W'(END_HOLD_CYCLES);
                tomWins_q <= (tomWins_q == '1) ? tomWins_q : tomWins_q + WIN_W'(1);
            end else if (enterJerry) begin
                state_q     <= JERRY_WON;
                gameEn_q    <= 1'b0;
                screen_q    <= 2'b11;
                hold_q      <= HOLD_W'(END_HOLD_CYCLES);
                jerryWins_q <= (jerryWins_q == '1) ? jerryWins_q : jerryWins_q + WIN_W'(1);
            end else begin
                case (state_q)
                    RESTART: begin
                        state_q  <= PLAYING;
                        gameEn_q <= 1'b1;
                    end
                    MENU, PLAYING, TOM_WON, JERRY_WON: ;
                    default: begin
                        state_q  <= MENU;
                        gameEn_q <= 1'b0;
                        screen_q <= 2'b00;
                    end
                endcase
            end
        end
    end

    assign game_en    = gameEn_q;
    assign game_rst   = gameRst_q;
    assign screen_sel = screen_q;
    assign tom_wins   = tomWins_q;
    assign jerry_wins = jerryWins_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: directed button/gameover sequences checked every cycle
// against a behavioural model of the round flow, plus hand-computed spot checks.
module tb_game_flow_ctrl;

    localparam int DB      = 4;
    localparam int HOLD    = 10;
    localparam int GUARD   = 2;
    localparam int WIN_W   = 4;
    localparam int WIN_MAX = (1 << WIN_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rst_button = 1'b0;
    logic [1:0]       gameover = 2'b00;
    logic             game_en, game_rst;
    logic [1:0]       screen_sel;
    logic [WIN_W-1:0] tom_wins, jerry_wins;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCnt   = 0;
    int rstPulses  = 0;
    int lastRstEdge = -100;

    // Behavioural model state: screen code plus a flag for the one-cycle round reset.
    bit hist[$] = '{1'b0, 1'b0};
    bit mLevel, mPress, mRstOut, mEn;
    int mRun, mScreen, mGuard, mHold, mTom, mJerry;

    game_flow_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .END_HOLD_CYCLES(HOLD),
        .GUARD_CYCLES(GUARD),
        .WIN_W(WIN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rst_button(rst_button),
        .gameover(gameover),
        .game_en(game_en),
        .game_rst(game_rst),
        .screen_sel(screen_sel),
        .tom_wins(tom_wins),
        .jerry_wins(jerry_wins)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end else begin
            passCount++;
        end
    endtask

    task automatic modelRestart();
        mScreen = 1;
        mRstOut = 1'b1;
        mEn     = 1'b0;
        mGuard  = GUARD;
    endtask

    task automatic modelStep();
        bit considered, pressNow, wasRestart;
        if (rst) begin
            hist = '{1'b0, 1'b0};
            mLevel = 0; mRun = 0; mPress = 0; mRstOut = 0; mEn = 0;
            mScreen = 0; mGuard = 0; mHold = 0; mTom = 0; mJerry = 0;
            return;
        end
        considered = hist.pop_front();
        hist.push_back(rst_button);
        pressNow = mPress;
        mPress = 1'b0;
        if (considered == mLevel) begin
            mRun = 0;
        end else begin
            mRun++;
            if (mRun == DB) begin
                mLevel = ~mLevel;
                mRun   = 0;
                mPress = mLevel;
            end
        end
        wasRestart = mRstOut;
        mRstOut = 1'b0;
        if (wasRestart) begin
            mEn = 1'b1;
        end else if (mScreen == 0) begin
            if (pressNow) modelRestart();
        end else if (mScreen == 1) begin
            if (mGuard > 0) begin
                mGuard--;
                if (pressNow) modelRestart();
            end else if (gameover[1]) begin
                mScreen = 2; mEn = 0; mHold = HOLD;
                if (mTom < WIN_MAX) mTom++;
            end else if (gameover[0]) begin
                mScreen = 3; mEn = 0; mHold = HOLD;
                if (mJerry < WIN_MAX) mJerry++;
            end else if (pressNow) begin
                modelRestart();
            end
        end else begin
            if (mHold > 0) mHold--;
            else if (pressNow) modelRestart();
        end
    endtask

    // Compare process: advance the model on each edge, check the DUT shortly after.
    initial begin
        forever begin
            @(posedge clk);
            cycleCnt++;
            modelStep();
            #1;
            checkOutput("screen_sel", 32'(screen_sel), 32'(mScreen));
            checkOutput("game_en", 32'(game_en), 32'(mEn));
            checkOutput("game_rst", 32'(game_rst), 32'(mRstOut));
            checkOutput("tom_wins", 32'(tom_wins), 32'(mTom));
            checkOutput("jerry_wins", 32'(jerry_wins), 32'(mJerry));
            if (game_rst === 1'b1) begin
                rstPulses++;
                lastRstEdge = cycleCnt;
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic btn, input logic [1:0] go, input int n);
        rst        = r;
        rst_button = btn;
        gameover   = go;
        repeat (n) @(negedge clk);
    endtask

    task automatic newRound();
        applyStimulus(1'b0, 1'b1, 2'b00, 8);
        applyStimulus(1'b0, 1'b0, 2'b00, 8);
    endtask

    int rawEdge, pulsesBefore, delta;

    initial begin
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 2'b00, 3);
        checkOutput("reset screen", 32'(screen_sel), 0);
        checkOutput("reset game_en", 32'(game_en), 0);
        checkOutput("reset tom", 32'(tom_wins), 0);
        checkOutput("reset jerry", 32'(jerry_wins), 0);

        // Short glitch: never reaches the debounced level.
        applyStimulus(1'b0, 1'b1, 2'b00, 3);
        applyStimulus(1'b0, 1'b0, 2'b00, 10);
        checkOutput("glitch no pulse", 32'(rstPulses), 0);
        checkOutput("glitch menu", 32'(screen_sel), 0);

        rawEdge = cycleCnt + 1;
        applyStimulus(1'b0, 1'b1, 2'b00, 20);
        delta = lastRstEdge - rawEdge;
        checkOutput("one game_rst", 32'(rstPulses), 1);
        checkOutput("press latency", 32'(delta == 6 || delta == 7), 1);
        checkOutput("playing screen", 32'(screen_sel), 1);
        checkOutput("playing en", 32'(game_en), 1);
        applyStimulus(1'b0, 1'b0, 2'b00, 8);

        applyStimulus(1'b0, 1'b0, 2'b10, 1);
        checkOutput("tom win screen", 32'(screen_sel), 2);
        checkOutput("tom win en", 32'(game_en), 0);
        checkOutput("tom win count", 32'(tom_wins), 1);
        applyStimulus(1'b0, 1'b0, 2'b00, 12);
        newRound();
        applyStimulus(1'b0, 1'b0, 2'b11, 1);
        checkOutput("illegal as tom screen", 32'(screen_sel), 2);
        checkOutput("illegal as tom count", 32'(tom_wins), 2);
        applyStimulus(1'b0, 1'b0, 2'b00, 12);

        // Guard window: gameover ignored for the first two playing cycles.
        applyStimulus(1'b0, 1'b1, 2'b00, 8);
        checkOutput("guard start screen", 32'(screen_sel), 1);
        applyStimulus(1'b0, 1'b0, 2'b01, 2);
        checkOutput("guard ignores", 32'(screen_sel), 1);
        checkOutput("guard jerry", 32'(jerry_wins), 0);
        applyStimulus(1'b0, 1'b0, 2'b01, 1);
        checkOutput("jerry screen", 32'(screen_sel), 3);
        checkOutput("jerry count", 32'(jerry_wins), 1);
        applyStimulus(1'b0, 1'b0, 2'b00, 12);
        newRound();

        // Press arrives while hold is 5: dropped.
        pulsesBefore = rstPulses;
        applyStimulus(1'b0, 1'b1, 2'b10, 1);
        applyStimulus(1'b0, 1'b1, 2'b00, 7);
        applyStimulus(1'b0, 1'b0, 2'b00, 4);
        checkOutput("hold drop screen", 32'(screen_sel), 2);
        checkOutput("hold drop pulses", 32'(rstPulses - pulsesBefore), 0);
        newRound();
        checkOutput("after hold screen", 32'(screen_sel), 1);
        checkOutput("after hold pulses", 32'(rstPulses - pulsesBefore), 1);
        checkOutput("after hold tom", 32'(tom_wins), 3);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b10, 1);
            applyStimulus(1'b0, 1'b0, 2'b00, 12);
            newRound();
        end
        checkOutput("tom saturated", 32'(tom_wins), 15);

        pulsesBefore = rstPulses;
        applyStimulus(1'b1, 1'b0, 2'b00, 1);
        checkOutput("midround rst screen", 32'(screen_sel), 0);
        checkOutput("midround rst en", 32'(game_en), 0);
        checkOutput("midround rst tom", 32'(tom_wins), 0);
        checkOutput("midround rst jerry", 32'(jerry_wins), 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 3);
        checkOutput("midround no pulse", 32'(rstPulses - pulsesBefore), 0);

        // Button held through reset yields a single press.
        applyStimulus(1'b1, 1'b1, 2'b00, 3);
        applyStimulus(1'b0, 1'b1, 2'b00, 14);
        checkOutput("held through rst pulses", 32'(rstPulses - pulsesBefore), 1);
        checkOutput("held through rst screen", 32'(screen_sel), 1);
        applyStimulus(1'b0, 1'b0, 2'b00, 2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
